// File: rtl/mem_c_unloader_if.sv
// Stream-side and MEM C read-port bundle for the MEM C unloader.
// master = unloader side, slave = memory/sink side.
interface mem_c_unloader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 22
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-3:0] mem_row;
  logic [1:0]        mem_col;
  logic              mem_nce;
  logic              mem_nwrt;
  logic [DATA_W-1:0] mem_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    input  start, mem_q, out_ready,
    output busy, done, mem_row, mem_col, mem_nce, mem_nwrt,
           out_valid, out_data, out_addr, out_last
  );

  modport slave (
    output start, mem_q, out_ready,
    input  busy, done, mem_row, mem_col, mem_nce, mem_nwrt,
           out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/mem_c_unloader.sv
// Streams all MEM C words in row-major order onto a valid/ready stream,
// issuing a read only when a 2-entry output FIFO slot is guaranteed.
//   state | meaning
//   IDLE  | waiting for start; read address parked
//   RUN   | issuing reads 0..4095 as FIFO space allows
//   DRAIN | all reads issued; emptying FIFO until word 4095 is accepted
module mem_c_unloader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  mem_c_unloader_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] infl_addr;
  logic              inflight;
  logic              done_q;

  logic [1:0]        occ;
  logic [DATA_W-1:0] d0, d1;
  logic [ADDR_W-1:0] a0, a1;
  logic              l0, l1;

  logic              out_valid_i;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        pending;
  logic              new_last;

  assign out_valid_i = (occ != 2'd0);
  assign pop         = out_valid_i & bus.out_ready;
  assign push        = inflight;
  assign pending     = {1'b0, occ} + {2'b00, inflight};
  // A read may go out only if its data is sure to find a free slot next edge.
  assign issue       = (state == S_RUN) && (pending < (3'd2 + {2'b00, pop}));
  assign new_last    = (infl_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      infl_addr <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (issue) infl_addr <= rd_addr;
      case (state)
        S_IDLE: begin
          // a start coinciding with the done pulse is deliberately dropped
          if (bus.start && !done_q) begin
            state   <= S_RUN;
            rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) state <= S_DRAIN;
            else                      rd_addr <= rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (pop && l0) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      a0  <= '0;
      a1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            d0 <= bus.mem_q; a0 <= infl_addr; l0 <= new_last;
          end else begin
            d1 <= bus.mem_q; a1 <= infl_addr; l1 <= new_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          d0  <= d1; a0 <= a1; l0 <= l1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            d0 <= bus.mem_q; a0 <= infl_addr; l0 <= new_last;
          end else begin
            d0 <= d1; a0 <= a1; l0 <= l1;
            d1 <= bus.mem_q; a1 <= infl_addr; l1 <= new_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.mem_nce   = ~issue;
  assign bus.mem_nwrt  = 1'b1;
  assign bus.mem_row   = rd_addr[ADDR_W-1:2];
  assign bus.mem_col   = rd_addr[1:0];
  assign bus.out_valid = out_valid_i;
  assign bus.out_data  = d0;
  assign bus.out_addr  = a0;
  assign bus.out_last  = l0 & out_valid_i;

endmodule
